ccu_ar_arbiter: RTL
===================

CCU_AR_ARBITER -- requirements
Module: ccu_ar_arbiter

Interface
REQ-001 SHALL have parameter NumMst, default 2, number of ACE masters sharing one read-snoop controller (>=1).
REQ-002 SHALL have parameter ar_chan_t, default logic, ACE AR channel struct type.
REQ-003 SHALL have parameter r_chan_t, default logic, ACE R channel struct type (carries last).
REQ-004 SHALL define IdxW = max(1, $clog2(NumMst)).
REQ-005 clk_i  input  1  clock; all state changes on rising edge.
REQ-006 rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 slv_ar_valid_i  input  NumMst  per-master AR valid.
REQ-008 slv_ar_i  input  NumMst x ar_chan_t  per-master AR payload.
REQ-009 slv_ar_ready_o  output  NumMst  per-master AR ready.
REQ-010 slv_r_valid_o  output  NumMst  per-master R valid.
REQ-011 slv_r_o  output  NumMst x r_chan_t  per-master R payload.
REQ-012 slv_r_ready_i  input  NumMst  per-master R ready.
REQ-013 slv_rack_i  input  NumMst  per-master ACE RACK pulse.
REQ-014 mst_ar_valid_o  output  1  AR valid to controller.
REQ-015 mst_ar_o  output  ar_chan_t  AR payload to controller.
REQ-016 mst_ar_ready_i  input  1  AR ready from controller.
REQ-017 mst_r_valid_i  input  1  R valid from controller.
REQ-018 mst_r_i  input  r_chan_t  R payload from controller.
REQ-019 mst_r_ready_o  output  1  R ready to controller.
REQ-020 busy_o  output  1  high whenever state != IDLE.
REQ-021 gnt_idx_o  output  IdxW  index of the currently granted master.

Function
REQ-022 SHALL implement FSM states IDLE, AR, R, ACK; one transaction in flight at a time.
REQ-023 IDLE: if any slv_ar_valid_i set, SHALL register the round-robin winner into gnt_idx and move to AR next cycle; with no valid, stay in IDLE.
REQ-024 Round robin: search starts at rr_ptr and wraps at NumMst-1 -> 0; the first valid index wins.
REQ-025 rr_ptr SHALL update to (gnt_idx+1) mod NumMst on the AR handshake only.
REQ-026 AR: mst_ar_valid_o = slv_ar_valid_i[gnt_idx], mst_ar_o = slv_ar_i[gnt_idx], slv_ar_ready_o[gnt_idx] = mst_ar_ready_i, all other slv_ar_ready_o = 0; on handshake -> R.
REQ-027 Outside AR, mst_ar_valid_o = 0 and all slv_ar_ready_o = 0; IDLE -> first AR handshake minimum latency is 1 cycle.
REQ-028 R: slv_r_valid_o[gnt_idx] = mst_r_valid_i, mst_r_ready_o = slv_r_ready_i[gnt_idx]; other slv_r_valid_o = 0.
REQ-029 slv_r_o[i] = mst_r_i for every i (payload broadcast, valid-gated).
REQ-030 R: on handshake with mst_r_i.last = 1 -> ACK; non-last beats stay in R; multi-beat bursts pass unmodified.
REQ-031 Outside R, mst_r_ready_o = 0 and all slv_r_valid_o = 0.
REQ-032 ACK: on slv_rack_i[gnt_idx] = 1 -> IDLE; RACK from other masters ignored in every state.
REQ-033 RACK asserted in the same cycle as the last R handshake SHALL be ignored; RACK is sampled only in ACK.
REQ-034 A master deasserting AR valid while in AR (protocol violation) SHALL NOT cause state change; the FSM holds AR.
REQ-035 gnt_idx_o SHALL be the registered gnt_idx, valid in AR/R/ACK, holding its last value in IDLE.

Reset
REQ-036 Reset asserted at any time, including mid-burst, SHALL immediately force state = IDLE, rr_ptr = 0, gnt_idx = 0; all valid/ready outputs 0, busy_o = 0.
REQ-037 After reset release, the first arbitration SHALL start from index 0.

Verification
REQ-038 NumMst=2, reset release, master 0 AR valid, ready=1 -> grant registered cycle 1, AR handshake cycle 2, gnt_idx_o=0, rr_ptr=1.
REQ-039 Masters 0 and 1 valid continuously, 4 single-beat transactions each with RACK -> grants alternate 0,1,0,1; no AR ready seen by the non-granted master.
REQ-040 Granted master 1, 4-beat burst with slv_r_ready_i[1] toggling -> 4 beats delivered in order to master 1 only, ACK entered after beat 4.
REQ-041 In ACK, RACK on master 0 while master 1 granted -> stays ACK; RACK on master 1 -> IDLE next cycle, busy_o=0.
REQ-042 Reset asserted during beat 2 of a burst -> all outputs 0 asynchronously; after release, next grant goes to lowest-index valid master.
REQ-043 RACK coincident with last R beat -> FSM waits in ACK for a fresh RACK before returning to IDLE.

Source files
------------

// File: rtl/ccu_ar_arbiter.sv
// ccu_ar_arbiter: shares one read-snoop controller among several ACE masters.
// One read transaction is in flight at a time. A round-robin pick chooses the
// master, its AR is forwarded, and its R burst is routed back to it. The
// arbiter then waits for that master's RACK before it arbitrates again.
module ccu_ar_arbiter #(
    parameter int unsigned  NumMst    = 2,
    parameter type          ar_chan_t = logic,
    parameter type          r_chan_t  = logic,
    // Bit position of the R "last" flag inside the packed r_chan_t
    parameter int unsigned  RLastBit  = 0,
    localparam int unsigned IdxW      = (NumMst > 1) ? $clog2(NumMst) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumMst-1:0] slv_ar_valid_i,
    input  ar_chan_t          slv_ar_i [NumMst],
    output logic [NumMst-1:0] slv_ar_ready_o,
    output logic [NumMst-1:0] slv_r_valid_o,
    output r_chan_t           slv_r_o [NumMst],
    input  logic [NumMst-1:0] slv_r_ready_i,
    input  logic [NumMst-1:0] slv_rack_i,
    output logic              mst_ar_valid_o,
    output ar_chan_t          mst_ar_o,
    input  logic              mst_ar_ready_i,
    input  logic              mst_r_valid_i,
    input  r_chan_t           mst_r_i,
    output logic              mst_r_ready_o,
    output logic              busy_o,
    output logic [IdxW-1:0]   gnt_idx_o
);

    localparam int unsigned     RW       = $bits(r_chan_t);
    localparam logic [RW-1:0]   LastMask = RW'(1) << RLastBit;

    typedef enum logic [1:0] {
        IDLE,
        AR,
        R,
        ACK
    } state_e;

    state_e            state_q;
    logic [IdxW-1:0]   gntIdx_q;
    logic [IdxW-1:0]   gntIdx_d;
    logic [IdxW-1:0]   rrPtr_q;
    logic [IdxW-1:0]   rrPtr_d;
    logic              anyValid;
    logic              arHs;
    logic              rHs;
    logic              rLast;

    assign anyValid  = |slv_ar_valid_i;
    assign rLast     = |(mst_r_i & LastMask);
    assign arHs      = (state_q == AR) && slv_ar_valid_i[gntIdx_q] && mst_ar_ready_i;
    assign rHs       = (state_q == R) && mst_r_valid_i && slv_r_ready_i[gntIdx_q];
    assign busy_o    = (state_q != IDLE);
    assign gnt_idx_o = gntIdx_q;
    assign rrPtr_d   = (gntIdx_q == IdxW'(NumMst - 1)) ? '0 : gntIdx_q + 1'b1;

    // Round-robin pick: the first valid master found at or after rrPtr_q, with wrap-around
    always_comb begin
        gntIdx_d = rrPtr_q;
        for (int k = int'(NumMst) - 1; k >= 0; k--) begin
            int idx;
            idx = int'(rrPtr_q) + k;
            if (idx >= int'(NumMst)) begin
                idx = idx - int'(NumMst);
            end
            if (slv_ar_valid_i[idx]) begin
                gntIdx_d = IdxW'(idx);
            end
        end
    end

    // Route the AR and R handshakes through the granted master only; R payload is broadcast
    always_comb begin
        slv_ar_ready_o = '0;
        slv_r_valid_o  = '0;
        mst_ar_valid_o = 1'b0;
        mst_r_ready_o  = 1'b0;
        mst_ar_o       = slv_ar_i[gntIdx_q];
        for (int i = 0; i < int'(NumMst); i++) begin
            slv_r_o[i] = mst_r_i;
        end
        case (state_q)
            AR: begin
                mst_ar_valid_o           = slv_ar_valid_i[gntIdx_q];
                slv_ar_ready_o[gntIdx_q] = mst_ar_ready_i;
            end
            R: begin
                slv_r_valid_o[gntIdx_q] = mst_r_valid_i;
                mst_r_ready_o           = slv_r_ready_i[gntIdx_q];
            end
            default: ;
        endcase
    end

    // Transaction FSM: grant, AR handshake, R burst until last, then wait for the grantee's RACK
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            gntIdx_q <= '0;
            rrPtr_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (anyValid) begin
                        gntIdx_q <= gntIdx_d;
                        state_q  <= AR;
                    end
                end
                AR: begin
                    if (arHs) begin
                        rrPtr_q <= rrPtr_d;
                        state_q <= R;
                    end
                end
                R: begin
                    if (rHs && rLast) begin
                        state_q <= ACK;
                    end
                end
                ACK: begin
                    if (slv_rack_i[gntIdx_q]) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
